// File: rtl/capture_pingpong_buffer.sv
`default_nettype none
// ============================================================================
// Module : capture_pingpong_buffer
// Multi-channel ping-pong ADC capture buffer with pre-trigger and auto trigger.
// Rev    : 1.0
// ============================================================================
module capture_pingpong_buffer #(
    parameter  int DATA_W   = 12,
    parameter  int CHANNELS = 2,
    parameter  int DEPTH    = 1024,
    parameter  int AUTO_TO  = 4096,
    localparam int c_AW     = $clog2(DEPTH),
    localparam int c_CW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sample_en,
    input  logic [CHANNELS*DATA_W-1:0] sample_data,
    input  logic                       stable,
    input  logic                       trig_in,
    input  logic                       trig_edge,
    input  logic                       auto_en,
    input  logic [c_AW-1:0]            pretrig,
    input  logic                       host_lock,
    input  logic                       host_rd,
    input  logic [c_CW+c_AW-1:0]       host_addr,
    output logic [DATA_W-1:0]          host_data,
    output logic                       host_valid,
    output logic                       host_ready,
    output logic                       trig_forced,
    output logic                       busy
);

    localparam int              c_TW      = $clog2(AUTO_TO + 1);
    localparam logic [c_TW-1:0] c_AUTO_TO = c_TW'(AUTO_TO);
    localparam logic [c_AW:0]   c_DEPTH   = (c_AW + 1)'(DEPTH);
    localparam logic [c_AW:0]   c_ONE     = (c_AW + 1)'(1);

    localparam logic [2:0] c_S_IDLE  = 3'd0;
    localparam logic [2:0] c_S_FILL  = 3'd1;
    localparam logic [2:0] c_S_ARMED = 3'd2;
    localparam logic [2:0] c_S_POST  = 3'd3;
    localparam logic [2:0] c_S_SWAP  = 3'd4;

    logic [2:0]       r_state;
    logic             r_wbank;
    logic [c_AW-1:0]  r_wptr;
    logic [c_AW-1:0]  r_pt;
    logic [c_AW:0]    r_cnt;
    logic [c_TW-1:0]  r_auto_cnt;
    logic             r_trig_prev;
    logic             r_trig_evt;
    logic             r_trig_pend;
    logic             r_forced;
    logic [c_AW-1:0]  r_start;
    logic [c_AW-1:0]  r_rd_start;
    logic             r_lock_prev;
    logic             r_host_ready;
    logic             r_trig_forced;
    logic             r_rd_v1;
    logic [c_CW-1:0]  r_rd_ch1;
    logic [DATA_W-1:0] r_host_data;
    logic             r_host_valid;

    logic                       w_edge;
    logic                       w_we;
    logic                       w_auto_fire;
    logic                       w_trig_now;
    logic [c_AW:0]              w_post_total;
    logic [c_AW:0]              w_waddr;
    logic [c_AW:0]              w_raddr;
    logic [CHANNELS*DATA_W-1:0] w_rd_all;
    logic [DATA_W-1:0]          w_sel;

    assign w_edge       = trig_edge ? (r_trig_prev & ~trig_in) : (~r_trig_prev & trig_in);
    assign w_we         = sample_en && ((r_state == c_S_FILL) || (r_state == c_S_ARMED) ||
                                        (r_state == c_S_POST));
    assign w_auto_fire  = auto_en && (r_auto_cnt == c_AUTO_TO);
    assign w_trig_now   = r_trig_pend | r_trig_evt | w_auto_fire;
    assign w_post_total = c_DEPTH - {1'b0, r_pt};
    assign w_waddr      = {r_wbank, r_wptr};
    assign w_raddr      = {~r_wbank, r_rd_start + host_addr[c_AW-1:0]};

    assign host_data   = r_host_data;
    assign host_valid  = r_host_valid;
    assign host_ready  = r_host_ready;
    assign trig_forced = r_trig_forced;
    assign busy        = (r_state != c_S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= c_S_IDLE;
            r_wbank       <= 1'b0;
            r_wptr        <= '0;
            r_pt          <= '0;
            r_cnt         <= '0;
            r_auto_cnt    <= '0;
            r_trig_prev   <= 1'b0;
            r_trig_evt    <= 1'b0;
            r_trig_pend   <= 1'b0;
            r_forced      <= 1'b0;
            r_start       <= '0;
            r_rd_start    <= '0;
            r_lock_prev   <= 1'b0;
            r_host_ready  <= 1'b0;
            r_trig_forced <= 1'b0;
        end else begin
            r_trig_prev <= trig_in;
            r_trig_evt  <= w_edge;
            r_lock_prev <= host_lock;
            if (host_lock && !r_lock_prev) begin
                r_host_ready <= 1'b0;
            end
            case (r_state)
                c_S_IDLE: begin
                    if (stable) begin
                        r_pt        <= pretrig;
                        r_wptr      <= '0;
                        r_cnt       <= '0;
                        r_auto_cnt  <= '0;
                        r_forced    <= 1'b0;
                        r_trig_pend <= 1'b0;
                        r_state     <= (pretrig == '0) ? c_S_ARMED : c_S_FILL;
                    end
                end
                c_S_FILL: begin
                    if (!stable) begin
                        r_state <= c_S_IDLE;
                    end else if (sample_en) begin
                        r_wptr <= r_wptr + 1'b1;
                        r_cnt  <= r_cnt + 1'b1;
                        if (r_cnt + 1'b1 == {1'b0, r_pt}) begin
                            r_state <= c_S_ARMED;
                        end
                    end
                end
                c_S_ARMED: begin
                    if (!stable) begin
                        r_state <= c_S_IDLE;
                    end else if (sample_en) begin
                        r_wptr <= r_wptr + 1'b1;
                        if (w_trig_now) begin
                            // The trigger sample itself is post sample 1.
                            r_start  <= r_wptr - r_pt;
                            r_forced <= w_auto_fire & ~(r_trig_pend | r_trig_evt);
                            r_cnt    <= c_ONE;
                            r_state  <= (w_post_total == c_ONE) ? c_S_SWAP : c_S_POST;
                        end else if (r_auto_cnt != c_AUTO_TO) begin
                            r_auto_cnt <= r_auto_cnt + 1'b1;
                        end
                    end else if (r_trig_evt) begin
                        r_trig_pend <= 1'b1;
                    end
                end
                c_S_POST: begin
                    if (!stable) begin
                        r_state <= c_S_IDLE;
                    end else if (sample_en) begin
                        r_wptr <= r_wptr + 1'b1;
                        r_cnt  <= r_cnt + 1'b1;
                        if (r_cnt + 1'b1 == w_post_total) begin
                            r_state <= c_S_SWAP;
                        end
                    end
                end
                c_S_SWAP: begin
                    // Host holds the read bank while locked; wait it out.
                    if (!host_lock) begin
                        r_wbank       <= ~r_wbank;
                        r_rd_start    <= r_start;
                        r_trig_forced <= r_forced;
                        r_host_ready  <= 1'b1;
                        r_state       <= c_S_IDLE;
                    end
                end
                default: r_state <= c_S_IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        logic [DATA_W-1:0] r_mem [0:2*DEPTH-1];
        logic [DATA_W-1:0] r_q;

        always_ff @(posedge clk) begin
            if (w_we) begin
                r_mem[w_waddr] <= sample_data[k*DATA_W +: DATA_W];
            end
            if (host_rd) begin
                r_q <= r_mem[w_raddr];
            end
        end

        assign w_rd_all[k*DATA_W +: DATA_W] = r_q;
    end

    always_comb begin
        w_sel = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (r_rd_ch1 == c_CW'(k)) begin
                w_sel = w_rd_all[k*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_v1      <= 1'b0;
            r_rd_ch1     <= '0;
            r_host_valid <= 1'b0;
            r_host_data  <= '0;
        end else begin
            r_rd_v1      <= host_rd;
            r_rd_ch1     <= host_addr[c_CW+c_AW-1:c_AW];
            r_host_valid <= r_rd_v1;
            if (r_rd_v1) begin
                r_host_data <= w_sel;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_capture_pingpong_buffer.sv
`default_nettype none
// ============================================================================
// Module : tb_capture_pingpong_buffer
// Directed self-checking bench for capture_pingpong_buffer (DEPTH=16).
// Rev    : 1.0
// ============================================================================
module tb_capture_pingpong_buffer;

    localparam int DATA_W   = 12;
    localparam int CHANNELS = 3;
    localparam int DEPTH    = 16;
    localparam int AUTO_TO  = 8;
    localparam int AW       = 4;
    localparam int CW       = 2;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic                       sample_en = 1'b0;
    logic [CHANNELS*DATA_W-1:0] sample_data = '0;
    logic                       stable = 1'b0;
    logic                       trig_in = 1'b0;
    logic                       trig_edge = 1'b0;
    logic                       auto_en = 1'b0;
    logic [AW-1:0]              pretrig = '0;
    logic                       host_lock = 1'b0;
    logic                       host_rd = 1'b0;
    logic [CW+AW-1:0]           host_addr = '0;
    logic [DATA_W-1:0]          host_data;
    logic                       host_valid;
    logic                       host_ready;
    logic                       trig_forced;
    logic                       busy;

    int tests_run    = 0;
    int tests_failed = 0;
    bit got;

    capture_pingpong_buffer #(
        .DATA_W  (DATA_W),
        .CHANNELS(CHANNELS),
        .DEPTH   (DEPTH),
        .AUTO_TO (AUTO_TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sample_en  (sample_en),
        .sample_data(sample_data),
        .stable     (stable),
        .trig_in    (trig_in),
        .trig_edge  (trig_edge),
        .auto_en    (auto_en),
        .pretrig    (pretrig),
        .host_lock  (host_lock),
        .host_rd    (host_rd),
        .host_addr  (host_addr),
        .host_data  (host_data),
        .host_valid (host_valid),
        .host_ready (host_ready),
        .trig_forced(trig_forced),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic start_capture(input int pt, input bit fall, input bit use_auto);
        stable    = 1'b0;
        sample_en = 1'b0;
        trig_in   = 1'b0;
        trig_edge = fall;
        auto_en   = use_auto;
        pretrig   = AW'(pt);
        repeat (2) @(negedge clk);
        stable = 1'b1;
        @(negedge clk);
        check("start_busy", 32'(busy), 32'd1);
    endtask

    // Sample n carries ch0 = base+n, ch1 = 100+base+n, ch2 = 200+base+n.
    // mode 1: trig_in rises with sample trig_at-1 (event lands on sample trig_at).
    // mode 2: rises at sample 3, falls with sample trig_at-1.
    task automatic stream(input int mode, input int trig_at, input int base, input int limit,
                          input bit stop_rdy, output bit seen);
        seen = 1'b0;
        for (int n = 0; n < limit; n++) begin
            sample_en   = 1'b1;
            sample_data = {DATA_W'(200 + base + n), DATA_W'(100 + base + n), DATA_W'(base + n)};
            case (mode)
                1:       trig_in = (n >= trig_at - 1);
                2:       trig_in = (n >= 3) && (n < trig_at - 1);
                default: trig_in = 1'b0;
            endcase
            @(negedge clk);
            if (stop_rdy && host_ready) begin
                seen = 1'b1;
                break;
            end
        end
        sample_en = 1'b0;
    endtask

    task automatic read_burst(input int ch, input int cnt, input int base, input string tag);
        int exp;
        for (int i = 0; i <= cnt; i++) begin
            host_rd   = (i < cnt);
            host_addr = {CW'(ch), AW'(i)};
            @(negedge clk);
            if (i >= 1) begin
                exp = (ch >= CHANNELS) ? 0 : ch * 100 + base + (i - 1);
                check($sformatf("%s_valid%0d", tag, i - 1), 32'(host_valid), 32'd1);
                check($sformatf("%s_data%0d", tag, i - 1), 32'(host_data), 32'(exp));
            end
        end
        host_rd = 1'b0;
        @(negedge clk);
        check($sformatf("%s_valid_end", tag), 32'(host_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_data",   32'(host_data),   32'd0);
        check("rst_valid",  32'(host_valid),  32'd0);
        check("rst_ready",  32'(host_ready),  32'd0);
        check("rst_forced", 32'(trig_forced), 32'd0);
        check("rst_busy",   32'(busy),        32'd0);
        rst = 1'b0;

        // Ramp capture, rising trigger on sample 20, pretrig 4.
        start_capture(4, 1'b0, 1'b0);
        stream(1, 20, 0, 200, 1'b1, got);
        check("t1_ready", 32'(got), 32'd1);
        check("t1_forced", 32'(trig_forced), 32'd0);
        stable    = 1'b0;
        host_lock = 1'b1;
        @(negedge clk);
        check("t1_lock_clr", 32'(host_ready), 32'd0);
        read_burst(0, 16, 16, "t1_ch0");
        read_burst(1, 16, 16, "t1_ch1");
        read_burst(2, 2, 16, "t1_ch2");
        read_burst(3, 2, 16, "t1_ch3");
        host_lock = 1'b0;

        // Ring wrapped twice before trigger on sample 40.
        start_capture(4, 1'b0, 1'b0);
        stream(1, 40, 0, 200, 1'b1, got);
        check("t2_ready", 32'(got), 32'd1);
        stable    = 1'b0;
        host_lock = 1'b1;
        read_burst(0, 16, 36, "t2_ch0");
        host_lock = 1'b0;

        // pretrig 0, falling edge on sample 9, earlier rising edge ignored.
        start_capture(0, 1'b1, 1'b0);
        stream(2, 9, 0, 200, 1'b1, got);
        check("t3_ready", 32'(got), 32'd1);
        check("t3_forced", 32'(trig_forced), 32'd0);
        stable    = 1'b0;
        host_lock = 1'b1;
        read_burst(0, 16, 9, "t3_ch0");
        host_lock = 1'b0;

        // Auto trigger: 8 ARMED strobes (samples 4..11), forced on sample 12.
        start_capture(4, 1'b0, 1'b1);
        stream(0, 0, 0, 200, 1'b1, got);
        check("t4_ready", 32'(got), 32'd1);
        check("t4_forced", 32'(trig_forced), 32'd1);
        stable    = 1'b0;
        auto_en   = 1'b0;
        host_lock = 1'b1;
        read_burst(0, 16, 8, "t4_ch0");

        // Capture completes while the host still holds the lock.
        start_capture(4, 1'b0, 1'b0);
        stream(1, 20, 0, 40, 1'b0, got);
        check("t5_busy_swap", 32'(busy), 32'd1);
        check("t5_ready_held", 32'(host_ready), 32'd0);
        check("t5_forced_old", 32'(trig_forced), 32'd1);
        read_burst(0, 2, 8, "t5_old");
        host_lock = 1'b0;
        stable    = 1'b0;
        @(negedge clk);
        check("t5_ready", 32'(host_ready), 32'd1);
        check("t5_forced", 32'(trig_forced), 32'd0);
        check("t5_idle", 32'(busy), 32'd0);

        // stable drops in POST: no swap, ready and read bank untouched.
        start_capture(4, 1'b0, 1'b0);
        stream(1, 22, 500, 26, 1'b0, got);
        stable = 1'b0;
        repeat (2) @(negedge clk);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_ready_kept", 32'(host_ready), 32'd1);
        check("t6_forced", 32'(trig_forced), 32'd0);
        host_lock = 1'b1;
        @(negedge clk);
        check("t6_lock_clr", 32'(host_ready), 32'd0);
        read_burst(0, 2, 16, "t6_keep");
        host_lock = 1'b0;

        // Asynchronous reset in the middle of FILL.
        start_capture(8, 1'b0, 1'b0);
        stream(0, 0, 0, 4, 1'b0, got);
        check("t7_fill_busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t7_rst_data",   32'(host_data),   32'd0);
        check("t7_rst_valid",  32'(host_valid),  32'd0);
        check("t7_rst_ready",  32'(host_ready),  32'd0);
        check("t7_rst_forced", 32'(trig_forced), 32'd0);
        check("t7_rst_busy",   32'(busy),        32'd0);
        @(negedge clk);
        stable = 1'b0;
        rst    = 1'b0;
        @(negedge clk);
        check("t7_idle", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
